mult_rr_sched: RTL
==================

# mult_rr_sched

Round-robin scheduler that shares one 8×8 multiplier between two source FIFOs and feeds the products into a single destination FIFO. It issues reads to the sources, runs the operand pairs through a registered two-stage multiply pipeline, and writes tagged results downstream. It replaces the direct `~EMPTY & ~almostFULL` read gating with exact credit tracking, so the destination FIFO can never overflow regardless of pipeline depth.

## Interface
- `DST_DEPTH`, 16: entry count of the destination FIFO; credit limit.
- `CLK` input 1: single clock, all state on rising edge.
- `RST` input 1: synchronous, active-high reset.
- `EN` input 1: 1 = new issues allowed; 0 = no new reads, in-flight items drain.
- `EMPTY0`, `EMPTY1` input 1: source FIFO empty flags.
- `DOUT0`, `DOUT1` input 16: source read data; `[15:8]` = a, `[7:0]` = b.
- `VALID0`, `VALID1` input 1: source read data valid, the cycle after the matching `RD`.
- `RD0`, `RD1` output 1: source read strobes; at most one high per cycle.
- `DST_RD` input 1: consumer read strobe on the destination FIFO.
- `WR_OUT` output 1: destination FIFO write strobe.
- `DIN_OUT` output 16: product a×b, unsigned.
- `SRC_OUT` output 1: source id of the current product (0 or 1).
- `CNT0`, `CNT1` output 16: products written per source.
- `ERR` output 1: sticky protocol error.

## Operation
- **Eligibility:**
  - Source k is eligible when `EN`=1, `EMPTYk`=0 and `occ + infl < DST_DEPTH`.
  - `occ` is the destination occupancy and `infl` is the number of issued-but-unwritten items. Both are registered.
- **Grant:**
  - `RDk` is combinational from the eligibility terms and the priority pointer `ptr`.
  - If both sources are eligible, grant `ptr`. If one is eligible, grant it.
  - After any grant to source k, `ptr` becomes `~k`. With no grant, `ptr` holds.
- **infl:**
  - +1 on a grant, −1 on `WR_OUT`; net 0 when both happen in the same cycle.
  - Range 0..3.
- **occ:**
  - +1 on `WR_OUT`, −1 on `DST_RD` when `occ` > 0; net 0 when both happen in the same cycle.
  - `DST_RD` with `occ` = 0 is ignored.
  - Width is clog2(`DST_DEPTH`+1).
- **Pipeline:**
  - Stage 1 captures `DOUTk`, the source id and a valid bit when `VALIDk`=1.
  - Stage 2 registers the 16-bit product a×b, the id and the valid bit.
  - `WR_OUT` = stage-2 valid; `DIN_OUT` and `SRC_OUT` are stage-2 registers.
  - The full 16-bit product is kept; 8×8 cannot overflow.
- **Counters:**
  - `CNTk` increments when `WR_OUT`=1 and `SRC_OUT`=k.
  - Wraps 0xFFFF→0x0000.
- **ERR:**
  - Set when `VALID0` and `VALID1` are high in the same cycle.
  - Set when `VALIDk` arrives without `RDk` in the previous cycle.
  - Cleared only by `RST`.
- **Reset values:**
  - `RD0`/`RD1`=0 while `RST`=1.
  - `WR_OUT`=0, `DIN_OUT`=0, `SRC_OUT`=0, `CNT0`/`CNT1`=0, `ERR`=0.
  - `ptr`=0, `occ`=0, `infl`=0, all pipeline valids 0.
- **Reset mid-operation:** in-flight items are discarded. The destination FIFO shares `RST`, so `occ`=0 stays consistent.

## Timing
- Cycle t: `RDk`=1. Cycle t+1: `VALIDk`=1, stage 1 loads. Cycle t+2: stage 2 loads. Cycle t+3: `WR_OUT`=1.
- Latency from `RD` to `WR_OUT` is 3 cycles. Throughput is 1 product/cycle while credit allows.
- Credit is checked against registered `occ` + `infl`, so an issue never causes more than `DST_DEPTH` entries.
- Freed credit is usable the cycle after the `DST_RD` / `WR_OUT` edge. There is no combinational path from `DST_RD` to `RD`.
- `EN` falling in cycle t blocks issues from cycle t on. Pending items still complete at t+1..t+3.

## Structure
- Package `mult_sched_pkg`:
  - `SRC0`/`SRC1` id constants.
  - `MUL_LAT` = 3.
  - Operand/product width constants (8/16).
- Sub-module `mult_pipe`: the two-stage registered 8×8 multiplier with valid and id sideband.
- Arbitration, credit counters, status counters and `ERR` live in the top module.

## Test plan
- Source0 holds {0x0304, 0x0A0B}, source1 is empty, `EN`=1, destination empty → `RD0` in cycles 0 and 1; `WR_OUT` in cycles 3 and 4 with `DIN_OUT` 0x000C then 0x006E; `SRC_OUT`=0; `CNT0`=2.
- Both sources always non-empty, `DST_RD` tied high → `RD` alternates 0,1,0,1 starting with 0; `CNT0`/`CNT1` are equal (or differ by 1) after 20 cycles.
- `DST_DEPTH`=4, `DST_RD`=0, both sources full → exactly 4 reads are issued, then `RD`=0 forever. A single `DST_RD` pulse → exactly one more read, the cycle after the pulse.
- Operands 0xFFFF → `DIN_OUT`=0xFE01. `CNT0` preset by 65536 writes → wraps to 0.
- Injected `VALID1` without a preceding `RD1` → `ERR`=1 the next cycle and stays high until `RST`.
- `RST` asserted one cycle after an issue → all outputs read their reset values the next cycle; the dropped item never produces `WR_OUT`.

Source files
------------

// File: rtl/mult_sched_pkg.sv
// Shared constants and payload types for the round-robin multiplier scheduler.
package mult_sched_pkg;

  localparam int unsigned OP_W    = 8;
  localparam int unsigned PROD_W  = 16;
  localparam int unsigned MUL_LAT = 3;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

  // Source FIFO word: a in the upper byte, b in the lower byte
  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } operands_t;

endpackage

// File: rtl/mult_pipe.sv
// Two-stage registered 8x8 unsigned multiplier carrying a valid bit and source id.
module mult_pipe
  import mult_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic              in_src,
  input  logic [PROD_W-1:0] in_data,
  output logic              out_vld,
  output logic              out_src,
  output logic [PROD_W-1:0] out_prod
);

  operands_t         s1_ops_q, s1_ops_d;
  logic              s1_vld_q, s1_vld_d;
  logic              s1_src_q, s1_src_d;
  logic              s2_vld_q, s2_vld_d;
  logic              s2_src_q, s2_src_d;
  logic [PROD_W-1:0] s2_prod_q, s2_prod_d;

  // Stage 1 captures operands on valid; stage 2 holds the full-width product
  always_comb begin
    s1_vld_d  = in_vld;
    s1_src_d  = s1_src_q;
    s1_ops_d  = s1_ops_q;
    s2_vld_d  = s1_vld_q;
    s2_src_d  = s2_src_q;
    s2_prod_d = s2_prod_q;
    if (in_vld) begin
      s1_src_d = in_src;
      s1_ops_d = operands_t'(in_data);
    end
    if (s1_vld_q) begin
      s2_src_d  = s1_src_q;
      s2_prod_d = PROD_W'(s1_ops_q.a) * PROD_W'(s1_ops_q.b);
    end
  end

  // Pipeline registers; reset discards anything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_src_q  <= 1'b0;
      s1_ops_q  <= '0;
      s2_vld_q  <= 1'b0;
      s2_src_q  <= 1'b0;
      s2_prod_q <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_src_q  <= s1_src_d;
      s1_ops_q  <= s1_ops_d;
      s2_vld_q  <= s2_vld_d;
      s2_src_q  <= s2_src_d;
      s2_prod_q <= s2_prod_d;
    end
  end

  assign out_vld  = s2_vld_q;
  assign out_src  = s2_src_q;
  assign out_prod = s2_prod_q;

endmodule

// File: rtl/mult_rr_sched.sv
// Round-robin scheduler sharing one multiplier between two source FIFOs, with
// exact credit tracking so the destination FIFO can never overflow.
module mult_rr_sched
  import mult_sched_pkg::*;
#(
  parameter int unsigned DST_DEPTH = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              EMPTY0,
  input  logic              EMPTY1,
  input  logic [PROD_W-1:0] DOUT0,
  input  logic [PROD_W-1:0] DOUT1,
  input  logic              VALID0,
  input  logic              VALID1,
  output logic              RD0,
  output logic              RD1,
  input  logic              DST_RD,
  output logic              WR_OUT,
  output logic [PROD_W-1:0] DIN_OUT,
  output logic              SRC_OUT,
  output logic [15:0]       CNT0,
  output logic [15:0]       CNT1,
  output logic              ERR
);

  localparam int unsigned OCC_W  = $clog2(DST_DEPTH + 1);
  localparam int unsigned INFL_W = 2;
  localparam int unsigned CRED_W = $clog2(DST_DEPTH + 4);
  localparam int unsigned CNT_W  = 16;

  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [INFL_W-1:0] infl_q, infl_d;
  logic              ptr_q, ptr_d;
  logic              rd0_prev_q, rd0_prev_d;
  logic              rd1_prev_q, rd1_prev_d;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d;
  logic [CNT_W-1:0]  cnt1_q, cnt1_d;
  logic              err_q, err_d;

  logic              credit_ok, elig0, elig1, gnt0, gnt1, gnt;
  logic              occ_dn;
  logic              pipe_vld, pipe_src;
  logic [PROD_W-1:0] pipe_din;
  logic              wr_vld, wr_src;
  logic [PROD_W-1:0] wr_prod;

  // Credit-gated eligibility and round-robin grant; only registered state feeds credit
  always_comb begin
    credit_ok = (CRED_W'(occ_q) + CRED_W'(infl_q)) < CRED_W'(DST_DEPTH);
    elig0     = ~RST & EN & ~EMPTY0 & credit_ok;
    elig1     = ~RST & EN & ~EMPTY1 & credit_ok;
    gnt0      = elig0 & (~elig1 | (ptr_q == SRC0));
    gnt1      = elig1 & (~elig0 | (ptr_q == SRC1));
    gnt       = gnt0 | gnt1;
  end

  assign RD0 = gnt0;
  assign RD1 = gnt1;

  // Returning read data into the multiplier; source 0 wins a protocol collision
  always_comb begin
    pipe_vld = VALID0 | VALID1;
    pipe_src = VALID0 ? SRC0 : SRC1;
    pipe_din = VALID0 ? DOUT0 : DOUT1;
  end

  mult_pipe u_pipe (
    .clk      (CLK),
    .rst      (RST),
    .in_vld   (pipe_vld),
    .in_src   (pipe_src),
    .in_data  (pipe_din),
    .out_vld  (wr_vld),
    .out_src  (wr_src),
    .out_prod (wr_prod)
  );

  // Next state for pointer, credit counters, product counters and error flag
  always_comb begin
    ptr_d      = ptr_q;
    infl_d     = infl_q;
    occ_d      = occ_q;
    rd0_prev_d = gnt0;
    rd1_prev_d = gnt1;
    occ_dn     = DST_RD & (occ_q != '0);

    if (gnt0) begin
      ptr_d = SRC1;
    end else if (gnt1) begin
      ptr_d = SRC0;
    end

    if (gnt && !wr_vld && (infl_q != '1)) begin
      infl_d = infl_q + INFL_W'(1);
    end else if (!gnt && wr_vld && (infl_q != '0)) begin
      infl_d = infl_q - INFL_W'(1);
    end

    if (wr_vld && !occ_dn && (occ_q != OCC_W'(DST_DEPTH))) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!wr_vld && occ_dn) begin
      occ_d = occ_q - OCC_W'(1);
    end

    cnt0_d = cnt0_q + CNT_W'(wr_vld & (wr_src == SRC0));
    cnt1_d = cnt1_q + CNT_W'(wr_vld & (wr_src == SRC1));

    err_d = err_q | (VALID0 & VALID1) | (VALID0 & ~rd0_prev_q) | (VALID1 & ~rd1_prev_q);
  end

  // Control state registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q      <= SRC0;
      infl_q     <= '0;
      occ_q      <= '0;
      rd0_prev_q <= 1'b0;
      rd1_prev_q <= 1'b0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      infl_q     <= infl_d;
      occ_q      <= occ_d;
      rd0_prev_q <= rd0_prev_d;
      rd1_prev_q <= rd1_prev_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
      err_q      <= err_d;
    end
  end

  assign WR_OUT  = wr_vld;
  assign DIN_OUT = wr_prod;
  assign SRC_OUT = wr_src;
  assign CNT0    = cnt0_q;
  assign CNT1    = cnt1_q;
  assign ERR     = err_q;

endmodule
